// File: rtl/tick_divider.sv
// Purpose : programmable periodic tick generator; one-cycle enable every P clocks.
// Latency : start seen on edge 0 -> count=0/busy=1 after edge 0; first enable after edge P.
// Backpr. : none; hold freezes the count and defers the next tick one cycle per held cycle.
//
// Ports:
//   clock, reset          system clock, asynchronous active-high reset
//   start, stop, hold     control: (re)start with sampled period/mode, abort, freeze
//   mode, period          0 = continuous / 1 = one-shot; cycles per tick (0 means 2^WIDTH)
//   enable, count, busy   registered tick pulse, current count 0..P-1, high while running
//   pulses                (only with TICK_DIVIDER_PULSECOUNT_EN) saturating pulse count
//                         since the last start

module tick_divider #(
    parameter int WIDTH          = 8,
    parameter int DEFAULT_PERIOD = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             hold,
    input  logic             mode,
    input  logic [WIDTH-1:0] period,
`ifdef TICK_DIVIDER_PULSECOUNT_EN
    output logic [WIDTH-1:0] pulses,
`endif
    output logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             busy
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic             m_q, m_d;
    logic             enable_q, enable_d;
    logic [WIDTH-1:0] last_count;

    // Terminal value in WIDTH-bit arithmetic: P = 0 wraps to all-ones,
    // which gives a full 2^WIDTH-cycle period.
    assign last_count = p_q - WIDTH'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            p_q      <= WIDTH'(DEFAULT_PERIOD);
            m_q      <= 1'b0;
            enable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            p_q      <= p_d;
            m_q      <= m_d;
            enable_q <= enable_d;
        end
    end

    // Priority: stop > start > hold > terminal count.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        p_d      = p_q;
        m_d      = m_q;
        enable_d = 1'b0;

        if (stop) begin
            state_d = IDLE;
            count_d = '0;
        end else if (start) begin
            // A terminal count coinciding with a restart is dropped.
            p_d     = period;
            m_d     = mode;
            count_d = '0;
            state_d = RUN;
        end else begin
            case (state_q)
                IDLE: begin
                    count_d = '0;
                end
                RUN: begin
                    if (!hold) begin
                        if (count_q == last_count) begin
                            count_d  = '0;
                            enable_d = 1'b1;
                            if (m_q) begin
                                state_d = IDLE;
                            end
                        end else begin
                            count_d = count_q + WIDTH'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    assign enable = enable_q;
    assign count  = count_q;
    assign busy   = (state_q == RUN);

`ifdef TICK_DIVIDER_PULSECOUNT_EN
    logic [WIDTH-1:0] pulses_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pulses_q <= '0;
        end else if (stop || start) begin
            pulses_q <= '0;
        end else if (enable_d && (pulses_q != {WIDTH{1'b1}})) begin
            pulses_q <= pulses_q + WIDTH'(1);
        end
    end

    assign pulses = pulses_q;
`endif

endmodule

// File: tb/tb_tick_divider.sv
module tb_tick_divider;

    logic       clock = 1'b0;
    always #5 clock = ~clock;

    // 8-bit instance
    logic       rst8 = 1'b1, start8 = 1'b0, stop8 = 1'b0, hold8 = 1'b0, mode8 = 1'b0;
    logic [7:0] period8 = 8'd0;
    logic       enable8, busy8;
    logic [7:0] count8;
`ifdef TICK_DIVIDER_PULSECOUNT_EN
    logic [7:0] pulses8;
`endif

    // 4-bit instance
    logic       rst4 = 1'b1, start4 = 1'b0, stop4 = 1'b0, hold4 = 1'b0, mode4 = 1'b0;
    logic [3:0] period4 = 4'd0;
    logic       enable4, busy4;
    logic [3:0] count4;
`ifdef TICK_DIVIDER_PULSECOUNT_EN
    logic [3:0] pulses4;
`endif

    int checks = 0;
    int fails  = 0;

    tick_divider #(.WIDTH(8), .DEFAULT_PERIOD(8)) u8 (
        .clock(clock), .reset(rst8), .start(start8), .stop(stop8), .hold(hold8),
        .mode(mode8), .period(period8),
`ifdef TICK_DIVIDER_PULSECOUNT_EN
        .pulses(pulses8),
`endif
        .enable(enable8), .count(count8), .busy(busy8)
    );

    tick_divider #(.WIDTH(4), .DEFAULT_PERIOD(8)) u4 (
        .clock(clock), .reset(rst4), .start(start4), .stop(stop4), .hold(hold4),
        .mode(mode4), .period(period4),
`ifdef TICK_DIVIDER_PULSECOUNT_EN
        .pulses(pulses4),
`endif
        .enable(enable4), .count(count4), .busy(busy4)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issues start on the next edge (edge 0); returns 1 ns after it.
    task automatic start_8(input logic [7:0] p, input logic m);
        period8 = p; mode8 = m; start8 = 1'b1;
        tick();
        start8 = 1'b0;
    endtask

    task automatic test_reset();
        tick();
        checks++; if ({enable8, busy8, count8} !== 10'd0) begin
            fails++; $display("FAIL reset8: got en=%0d busy=%0d count=%0d expected 0/0/0", enable8, busy8, count8);
        end
        checks++; if ({enable4, busy4, count4} !== 6'd0) begin
            fails++; $display("FAIL reset4: got en=%0d busy=%0d count=%0d expected 0/0/0", enable4, busy4, count4);
        end
        rst8 = 1'b0; rst4 = 1'b0;
        tick();
        checks++; if ({enable8, busy8, count8} !== 10'd0) begin
            fails++; $display("FAIL idle_after_reset: got en=%0d busy=%0d count=%0d expected 0/0/0", enable8, busy8, count8);
        end
    endtask

    task automatic test_continuous();
        start_8(8'd8, 1'b0);
        checks++; if (count8 !== 8'd0 || busy8 !== 1'b1 || enable8 !== 1'b0) begin
            fails++; $display("FAIL cont_start: got count=%0d busy=%0d en=%0d expected 0/1/0", count8, busy8, enable8);
        end
        for (int e = 1; e <= 40; e++) begin
            tick();
            checks++; if (enable8 !== ((e % 8) == 0) || count8 !== 8'(e % 8)) begin
                fails++; $display("FAIL cont_edge%0d: got en=%0d count=%0d expected en=%0d count=%0d",
                                  e, enable8, count8, ((e % 8) == 0), e % 8);
            end
        end
        stop8 = 1'b1; tick(); stop8 = 1'b0;
        checks++; if (busy8 !== 1'b0 || count8 !== 8'd0 || enable8 !== 1'b0) begin
            fails++; $display("FAIL cont_stop: got busy=%0d count=%0d en=%0d expected 0/0/0", busy8, count8, enable8);
        end
    endtask

    task automatic test_one_shot();
        start_8(8'd3, 1'b1);
        for (int e = 1; e <= 8; e++) begin
            tick();
            checks++; if (enable8 !== (e == 3) || busy8 !== (e < 3) || count8 !== 8'(e < 3 ? e : 0)) begin
                fails++; $display("FAIL oneshot_edge%0d: got en=%0d busy=%0d count=%0d expected en=%0d busy=%0d count=%0d",
                                  e, enable8, busy8, count8, (e == 3), (e < 3), (e < 3 ? e : 0));
            end
        end
    endtask

    task automatic test_hold();
        start_8(8'd8, 1'b0);
        for (int e = 1; e <= 5; e++) tick();
        checks++; if (count8 !== 8'd5) begin
            fails++; $display("FAIL hold_pre: got count=%0d expected 5", count8);
        end
        hold8 = 1'b1;
        for (int e = 6; e <= 9; e++) begin
            tick();
            checks++; if (count8 !== 8'd5 || enable8 !== 1'b0) begin
                fails++; $display("FAIL hold_edge%0d: got count=%0d en=%0d expected 5/0", e, count8, enable8);
            end
        end
        hold8 = 1'b0;
        for (int e = 10; e <= 12; e++) begin
            tick();
            checks++; if (enable8 !== (e == 12) || count8 !== 8'(e == 12 ? 0 : e - 4)) begin
                fails++; $display("FAIL hold_resume%0d: got en=%0d count=%0d expected en=%0d count=%0d",
                                  e, enable8, count8, (e == 12), (e == 12 ? 0 : e - 4));
            end
        end
        stop8 = 1'b1; tick(); stop8 = 1'b0;
    endtask

    task automatic test_stop_start_priority();
        start_8(8'd4, 1'b0);
        for (int e = 1; e <= 3; e++) tick();
        stop8 = 1'b1; start8 = 1'b1;
        tick();
        stop8 = 1'b0; start8 = 1'b0;
        checks++; if (enable8 !== 1'b0 || busy8 !== 1'b0 || count8 !== 8'd0) begin
            fails++; $display("FAIL stop_start_terminal: got en=%0d busy=%0d count=%0d expected 0/0/0", enable8, busy8, count8);
        end
        start_8(8'd4, 1'b0);
        for (int e = 1; e <= 3; e++) tick();
        checks++; if (count8 !== 8'd3) begin
            fails++; $display("FAIL restart_pre: got count=%0d expected 3", count8);
        end
        start_8(8'd6, 1'b0);
        checks++; if (enable8 !== 1'b0 || busy8 !== 1'b1 || count8 !== 8'd0) begin
            fails++; $display("FAIL restart_terminal: got en=%0d busy=%0d count=%0d expected 0/1/0", enable8, busy8, count8);
        end
        for (int e = 1; e <= 6; e++) begin
            tick();
            checks++; if (enable8 !== (e == 6) || count8 !== 8'(e % 6)) begin
                fails++; $display("FAIL restart_edge%0d: got en=%0d count=%0d expected en=%0d count=%0d",
                                  e, enable8, count8, (e == 6), e % 6);
            end
        end
        stop8 = 1'b1; tick(); stop8 = 1'b0;
    endtask

    task automatic test_period_zero_and_reset();
        period4 = 4'd0; mode4 = 1'b0; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        for (int e = 1; e <= 16; e++) begin
            tick();
            checks++; if (enable4 !== (e == 16) || count4 !== 4'(e % 16)) begin
                fails++; $display("FAIL p0_edge%0d: got en=%0d count=%0d expected en=%0d count=%0d",
                                  e, enable4, count4, (e == 16), e % 16);
            end
        end
        tick(); tick(); tick();
        checks++; if (count4 !== 4'd3 || busy4 !== 1'b1) begin
            fails++; $display("FAIL p0_mid: got count=%0d busy=%0d expected 3/1", count4, busy4);
        end
        for (int e = 4; e <= 16; e++) tick();
        checks++; if (enable4 !== 1'b1) begin
            fails++; $display("FAIL p0_second_pulse: got en=%0d expected 1", enable4);
        end
        rst4 = 1'b1;
        #1;
        checks++; if (enable4 !== 1'b0 || count4 !== 4'd0 || busy4 !== 1'b0) begin
            fails++; $display("FAIL async_reset: got en=%0d count=%0d busy=%0d expected 0/0/0", enable4, count4, busy4);
        end
        tick();
        rst4 = 1'b0;
        tick();
        checks++; if (enable4 !== 1'b0 || busy4 !== 1'b0) begin
            fails++; $display("FAIL post_reset_idle: got en=%0d busy=%0d expected 0/0", enable4, busy4);
        end
    endtask

`ifdef TICK_DIVIDER_PULSECOUNT_EN
    task automatic test_pulse_count();
        period4 = 4'd1; mode4 = 1'b0; start4 = 1'b1;
        tick();
        start4 = 1'b0;
        checks++; if (pulses4 !== 4'd0) begin
            fails++; $display("FAIL pulses_start: got %0d expected 0", pulses4);
        end
        for (int e = 1; e <= 20; e++) begin
            tick();
            checks++; if (pulses4 !== 4'(e > 15 ? 15 : e) || enable4 !== 1'b1) begin
                fails++; $display("FAIL pulses_edge%0d: got pulses=%0d en=%0d expected pulses=%0d en=1",
                                  e, pulses4, enable4, (e > 15 ? 15 : e));
            end
        end
        stop4 = 1'b1; tick(); stop4 = 1'b0;
        checks++; if (pulses4 !== 4'd0) begin
            fails++; $display("FAIL pulses_stop: got %0d expected 0", pulses4);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_continuous();
        test_one_shot();
        test_hold();
        test_stop_start_priority();
        test_period_zero_and_reset();
`ifdef TICK_DIVIDER_PULSECOUNT_EN
        test_pulse_count();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/tick_divider.md
# tick_divider

Parametrised programmable tick generator: counts clock cycles and emits a single-cycle `enable` pulse every `period` cycles. It replaces fixed divide-by-eight enable generators, adding runtime-loadable period, continuous or one-shot mode, pause and abort. It sits between the system clock and any datapath stage that needs a periodic strobe.

## Interface
- `WIDTH`, 8, width of counter, period and count output.
- `DEFAULT_PERIOD`, 8, period loaded at reset; used until the first `start`.
- `clock`  in  1  system clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  sample `period` and `mode`, clear count, enter RUN.
- `stop`  in  1  abort; return to IDLE.
- `hold`  in  1  freeze count while in RUN.
- `mode`  in  1  0 = continuous, 1 = one-shot; sampled with `start`.
- `period`  in  WIDTH  cycles per tick; sampled with `start`; 0 means 2^WIDTH.
- `enable`  out  1  registered tick pulse, high for exactly one cycle.
- `count`  out  WIDTH  current count, 0 .. P-1.
- `busy`  out  1  high in RUN.

## Operation
- States: IDLE, RUN.
- Latched registers: P (period) and M (mode). Reset loads P = `DEFAULT_PERIOD` and M = 0.
- Reset values: state IDLE, `count` = 0, `enable` = 0, `busy` = 0.
- IDLE:
  - `count` holds 0 and `enable` = 0.
  - `start` loads P and M, sets `count` to 0 and enters RUN.
- RUN, `hold` = 0:
  - If `count` == P-1 (WIDTH-bit arithmetic, so P = 0 gives all-ones, i.e. 2^WIDTH): `count` goes to 0 and `enable` goes to 1 on that edge.
  - Otherwise `count` increments.
  - One-shot mode: the terminal edge also moves the state to IDLE.
- RUN, `hold` = 1: `count` frozen and `enable` = 0. A terminal condition is not evaluated while held.
- `enable` is 0 on every edge that does not set it.
- Priority, highest first: `stop`, `start`, `hold`, terminal count.
  - `stop` (with or without `start`): IDLE, `count` 0, no pulse.
  - `start` in RUN: restarts with the newly sampled P and M. Any terminal count on the same edge is discarded, with no pulse.
- `period`/`mode` changes outside a `start` cycle have no effect.
- Reset mid-operation immediately forces the reset values, including dropping an `enable` that is high. P and M return to their defaults.

## Timing
- `start` sampled at edge 0 → `count` = 0 after edge 0, `busy` = 1 after edge 0.
- First `enable` is high in the cycle after edge P (period P, no hold). It then repeats every P cycles, each pulse one cycle wide.
- P = 1: `enable` is high continuously from edge 1 onward in continuous mode. In one-shot mode it is a single pulse after edge 1.
- Each held cycle delays the next pulse by exactly one cycle.
- One-shot: `busy` falls on the same edge `enable` rises.
- All outputs are registered; there is no combinational input-to-output path.

## Configuration
- `TICK_DIVIDER_PULSECOUNT_EN` defined:
  - Adds output `pulses` (out, WIDTH): number of `enable` pulses since the last `start`.
  - Saturates at all-ones.
  - Cleared by reset, `start` and `stop`.
  - Increments on the same edge `enable` is set.
- Not defined: the `pulses` port and its logic are absent; all other behaviour is identical.

## Test plan
- Reset, then `start` with period 8, mode 0, running 40 cycles → `enable` pulses after edges 8, 16, 24, 32, 40 and `count` cycles 0..7.
- `start` with period 3, mode 1 → a single pulse after edge 3, `busy` falls on that edge, then `count` stays 0 with no further pulses.
- Period 8, `hold` high for 4 cycles starting when `count` = 5 → `count` frozen at 5, next pulse delayed by 4 cycles (after edge 12).
- Period 4 with `stop` and `start` asserted on the terminal edge (`count` = 3) → IDLE, no pulse. Repeat with `start` alone → no pulse, `count` = 0, new period in effect.
- WIDTH = 4, period 0 → pulses every 16 cycles. Assert `reset` while `enable` is high → `enable`, `count` and `busy` drop to 0 immediately.
- With `TICK_DIVIDER_PULSECOUNT_EN`, WIDTH = 4, period 1, mode 0 → `pulses` counts 1..15, then saturates at 15.
